// File: rtl/editor_fecha_pkg.sv
// Shared constants, field codes and calendar helpers
// for the date editor and its BCD step counter.
package editor_fecha_pkg;

  typedef enum logic [1:0] {
    DIA  = 2'd0,
    MES  = 2'd1,
    YEAR = 2'd2
  } campo_t;

  localparam logic [7:0] HOLD_CYCLES = 8'd255;

  localparam logic [7:0] RST_DIA  = 8'h01;
  localparam logic [7:0] RST_MES  = 8'h01;
  localparam logic [7:0] RST_YEAR = 8'h16;

  localparam logic [7:0] DIA_MIN  = 8'h01;
  localparam logic [7:0] MES_MIN  = 8'h01;
  localparam logic [7:0] MES_MAX  = 8'h12;
  localparam logic [7:0] YEAR_MIN = 8'h00;
  localparam logic [7:0] YEAR_MAX = 8'h99;

  localparam logic [7:0] DIAS_31  = 8'h31;
  localparam logic [7:0] DIAS_30  = 8'h30;
  localparam logic [7:0] DIAS_FEB = 8'h28;
  localparam logic [7:0] DIAS_BIS = 8'h29;

  // Two-digit year; 00 counts as leap (2000).
  function automatic logic es_bisiesto(
    input logic [7:0] y
  );
    logic [6:0] v;
    v = 7'(y[7:4]) * 7'd10 + 7'(y[3:0]);
    return (v[1:0] == 2'b00);
  endfunction

  function automatic logic [7:0] max_dia(
    input logic [7:0] m,
    input logic [7:0] y
  );
    logic [7:0] r;
    case (m)
      8'h04, 8'h06,
      8'h09, 8'h11: r = DIAS_30;
      8'h02:        r = es_bisiesto(y) ?
                        DIAS_BIS : DIAS_FEB;
      default:      r = DIAS_31;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/editor_fecha_contador_bcd.sv
// Two-digit packed BCD up/down step with wrap.
// Ports: i_val current, i_up/i_down step request,
// i_min/i_max wrap limits, o_val next value.
module contador_bcd (
  input  logic [7:0] i_val,
  input  logic       i_up,
  input  logic       i_down,
  input  logic [7:0] i_min,
  input  logic [7:0] i_max,
  output logic [7:0] o_val
);

  always_comb begin
    o_val = i_val;
    if (i_up && !i_down) begin
      if (i_val >= i_max)
        o_val = i_min;
      else if (i_val[3:0] == 4'd9)
        o_val = {i_val[7:4] + 4'd1, 4'd0};
      else
        o_val = {i_val[7:4], i_val[3:0] + 4'd1};
    end else if (i_down && !i_up) begin
      if (i_val <= i_min)
        o_val = i_max;
      else if (i_val[3:0] == 4'd0)
        o_val = {i_val[7:4] - 4'd1, 4'd9};
      else
        o_val = {i_val[7:4], i_val[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/editor_fecha.sv
// Date editor: buttons edit dia/mes/year in BCD,
// save emits chs and freezes values for 255 clocks.
// Ports: clock, reset (sync high), edit_en,
// btn_up/down/next/save levels; dia, mes, year,
// campo, chs, lock registered outputs.
module editor_fecha
  import editor_fecha_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       edit_en,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic       btn_save,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] year,
  output logic [1:0] campo,
  output logic       chs,
  output logic       lock
);

  logic [7:0] r_dia;
  logic [7:0] r_mes;
  logic [7:0] r_year;
  campo_t     r_campo;
  logic       r_chs;
  logic       r_lock;
  logic [7:0] r_cnt;

  logic r_up_prev;
  logic r_down_prev;
  logic r_next_prev;
  logic r_save_prev;

  logic w_ev_up;
  logic w_ev_down;
  logic w_ev_next;
  logic w_ev_save;
  logic w_ok;
  logic w_save;
  logic w_next;
  logic w_up;
  logic w_down;
  logic [7:0] w_max;
  logic       w_clamp;
  campo_t     w_campo_nxt;

  logic [7:0] w_dia_nxt;
  logic [7:0] w_mes_nxt;
  logic [7:0] w_year_nxt;

  assign w_ev_up   = btn_up   & ~r_up_prev;
  assign w_ev_down = btn_down & ~r_down_prev;
  assign w_ev_next = btn_next & ~r_next_prev;
  assign w_ev_save = btn_save & ~r_save_prev;

  assign w_ok = edit_en & ~r_lock;

  // One action per clock; up+down cancels.
  assign w_save = w_ok & w_ev_save;
  assign w_next = w_ok & w_ev_next & ~w_ev_save;
  assign w_up   = w_ok & w_ev_up & ~w_ev_down
                & ~w_ev_save & ~w_ev_next;
  assign w_down = w_ok & w_ev_down & ~w_ev_up
                & ~w_ev_save & ~w_ev_next;

  // BCD ordering matches binary ordering.
  assign w_max   = max_dia(r_mes, r_year);
  assign w_clamp = (r_dia > w_max);

  always_comb begin
    w_campo_nxt = r_campo;
    if (w_next) begin
      unique case (r_campo)
        DIA:     w_campo_nxt = MES;
        MES:     w_campo_nxt = YEAR;
        default: w_campo_nxt = DIA;
      endcase
    end
  end

  contador_bcd u_dia (
    .i_val  (r_dia),
    .i_up   (w_up   & (r_campo == DIA)),
    .i_down (w_down & (r_campo == DIA)),
    .i_min  (DIA_MIN),
    .i_max  (w_max),
    .o_val  (w_dia_nxt)
  );

  contador_bcd u_mes (
    .i_val  (r_mes),
    .i_up   (w_up   & (r_campo == MES)),
    .i_down (w_down & (r_campo == MES)),
    .i_min  (MES_MIN),
    .i_max  (MES_MAX),
    .o_val  (w_mes_nxt)
  );

  contador_bcd u_year (
    .i_val  (r_year),
    .i_up   (w_up   & (r_campo == YEAR)),
    .i_down (w_down & (r_campo == YEAR)),
    .i_min  (YEAR_MIN),
    .i_max  (YEAR_MAX),
    .o_val  (w_year_nxt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dia       <= RST_DIA;
      r_mes       <= RST_MES;
      r_year      <= RST_YEAR;
      r_campo     <= DIA;
      r_chs       <= 1'b0;
      r_lock      <= 1'b0;
      r_cnt       <= 8'd0;
      // Held buttons must not fire on release of reset.
      r_up_prev   <= 1'b1;
      r_down_prev <= 1'b1;
      r_next_prev <= 1'b1;
      r_save_prev <= 1'b1;
    end else begin
      r_up_prev   <= btn_up;
      r_down_prev <= btn_down;
      r_next_prev <= btn_next;
      r_save_prev <= btn_save;
      r_chs       <= w_save;

      // Lock covers the save clock plus 254 more.
      if (r_lock) begin
        if (r_cnt == 8'd0)
          r_lock <= 1'b0;
        else
          r_cnt <= r_cnt - 8'd1;
      end else if (w_save) begin
        r_lock <= 1'b1;
        r_cnt  <= HOLD_CYCLES - 8'd1;
      end

      // Clamp still resolves on the save edge,
      // so frozen values are always legal.
      if (!r_lock) begin
        if (w_clamp)
          r_dia <= w_max;
        else
          r_dia <= w_dia_nxt;
        r_mes   <= w_mes_nxt;
        r_year  <= w_year_nxt;
        r_campo <= w_campo_nxt;
      end
    end
  end

  assign dia   = r_dia;
  assign mes   = r_mes;
  assign year  = r_year;
  assign campo = r_campo;
  assign chs   = r_chs;
  assign lock  = r_lock;

endmodule

// File: tb/tb_editor_fecha.sv
// Scoreboard bench for editor_fecha: stimulus
// queues expectations, a monitor checks them.
module tb_editor_fecha;

  logic       clock = 1'b0;
  logic       reset;
  logic       edit_en;
  logic       btn_up;
  logic       btn_down;
  logic       btn_next;
  logic       btn_save;
  logic [7:0] dia;
  logic [7:0] mes;
  logic [7:0] year;
  logic [1:0] campo;
  logic       chs;
  logic       lock;

  editor_fecha dut (
    .clock    (clock),
    .reset    (reset),
    .edit_en  (edit_en),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_next (btn_next),
    .btn_save (btn_save),
    .dia      (dia),
    .mes      (mes),
    .year     (year),
    .campo    (campo),
    .chs      (chs),
    .lock     (lock)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    int         at;
    logic [7:0] d;
    logic [7:0] m;
    logic [7:0] y;
    logic [1:0] c;
    logic       s;
    logic       l;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ls;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      e_m = q.pop_front();
      checks++;
      if ({dia, mes, year, campo, chs, lock} !==
          {e_m.d, e_m.m, e_m.y, e_m.c, e_m.s, e_m.l}) begin
        errors++;
        $display("FAIL %s: got d=%h m=%h y=%h c=%0d chs=%b lock=%b want d=%h m=%h y=%h c=%0d chs=%b lock=%b",
          e_m.name, dia, mes, year, campo, chs, lock,
          e_m.d, e_m.m, e_m.y, e_m.c, e_m.s, e_m.l);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(
    input string      n,
    input logic [7:0] d,
    input logic [7:0] m,
    input logic [7:0] y,
    input logic [1:0] c,
    input logic       s,
    input logic       l
  );
    exp_t e;
    e.name = n; e.at = cyc;
    e.d = d; e.m = m; e.y = y;
    e.c = c; e.s = s; e.l = l;
    q.push_back(e);
  endtask

  task automatic press(
    input logic u,
    input logic d,
    input logic n,
    input logic s
  );
    btn_up = u; btn_down = d;
    btn_next = n; btn_save = s;
    tick();
    btn_up = 0; btn_down = 0;
    btn_next = 0; btn_save = 0;
    tick();
  endtask

  task automatic up();   press(1, 0, 0, 0); endtask
  task automatic down(); press(0, 1, 0, 0); endtask
  task automatic nxt();  press(0, 0, 1, 0); endtask

  initial begin
    reset = 1; edit_en = 1;
    btn_up = 0; btn_down = 0;
    btn_next = 0; btn_save = 0;
    tick(); tick();
    chk("reset", 8'h01, 8'h01, 8'h16, 0, 0, 0);
    reset = 0;
    tick();

    nxt(); up(); nxt(); nxt();
    for (int i = 0; i < 28; i++) up();
    chk("setup29", 8'h29, 8'h02, 8'h16, 0, 0, 0);
    up();
    chk("dia_wrap_up", 8'h01, 8'h02, 8'h16, 0, 0, 0);

    nxt(); nxt(); up(); nxt();
    down();
    chk("dia_wrap_dn", 8'h28, 8'h02, 8'h17, 0, 0, 0);

    nxt(); down(); nxt(); down(); nxt();
    up(); up(); up();
    chk("dia31", 8'h31, 8'h01, 8'h16, 0, 0, 0);

    nxt();
    btn_up = 1;
    tick();
    chk("mes_chg", 8'h31, 8'h02, 8'h16, 1, 0, 0);
    btn_up = 0;
    tick();
    chk("clamp", 8'h29, 8'h02, 8'h16, 1, 0, 0);

    nxt();
    for (int i = 0; i < 17; i++) down();
    chk("yr99", 8'h28, 8'h02, 8'h99, 2, 0, 0);
    up();
    chk("yr_up_wrap", 8'h28, 8'h02, 8'h00, 2, 0, 0);
    down();
    chk("yr_dn_wrap", 8'h28, 8'h02, 8'h99, 2, 0, 0);
    press(1, 1, 0, 0);
    chk("updown", 8'h28, 8'h02, 8'h99, 2, 0, 0);

    edit_en = 0;
    nxt();
    chk("edit_off", 8'h28, 8'h02, 8'h99, 2, 0, 0);
    edit_en = 1;
    press(1, 0, 1, 0);
    chk("prio", 8'h28, 8'h02, 8'h99, 0, 0, 0);
    nxt(); nxt();

    btn_save = 1;
    tick();
    ls = cyc;
    chk("save", 8'h28, 8'h02, 8'h99, 2, 1, 1);
    btn_save = 0;
    tick();
    chk("chs_pulse", 8'h28, 8'h02, 8'h99, 2, 0, 1);
    while (cyc < ls + 49) tick();
    up();
    chk("lock_up", 8'h28, 8'h02, 8'h99, 2, 0, 1);
    while (cyc < ls + 59) tick();
    edit_en = 0;
    while (cyc < ls + 199) tick();
    edit_en = 1;
    while (cyc < ls + 254) tick();
    chk("lock255", 8'h28, 8'h02, 8'h99, 2, 0, 1);
    tick();
    chk("unlock", 8'h28, 8'h02, 8'h99, 2, 0, 0);
    up();
    chk("post_lock", 8'h28, 8'h02, 8'h00, 2, 0, 0);

    btn_save = 1;
    tick();
    ls = cyc;
    chk("save2", 8'h28, 8'h02, 8'h00, 2, 1, 1);
    btn_save = 0;
    while (cyc < ls + 99) tick();
    reset = 1;
    btn_up = 1;
    tick();
    chk("rst_lock", 8'h01, 8'h01, 8'h16, 0, 0, 0);
    reset = 0;
    tick();
    chk("held_rst", 8'h01, 8'h01, 8'h16, 0, 0, 0);
    btn_up = 0;
    tick();
    up();
    chk("after_rst", 8'h02, 8'h01, 8'h16, 0, 0, 0);

    tick(); tick(); tick();
    if (q.size() != 0) begin
      checks += q.size();
      errors += q.size();
      $display("FAIL pending: got %0d unchecked want 0",
        q.size());
    end
    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end

endmodule
